segment_txt_scroll: RTL and testbench

//  Upstream feeder for the 7-segment text character table. It buffers a text message of
//  6-bit character codes (0x00-0x24; 0x3F = blank) written by a host, time-multiplexes

---
 rtl/segment_txt_scroll.sv | 233 +++++++++++++++++++++++
 tb/tb_segment_txt_scroll.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/segment_txt_scroll.sv
// Message buffer, digit scanner and scroller feeding a 7-segment character table.
// Optional blink feature: define SEGMENT_TXT_SCROLL_BLINK_EN to add i_blink and BLINK_DIV.
module segment_txt_scroll #(
    parameter int DIGITS     = 8,
    parameter int MSG_DEPTH  = 32,
    parameter int SCAN_DIV   = 50000,
    parameter int SCROLL_DIV = 25000000
`ifdef SEGMENT_TXT_SCROLL_BLINK_EN
    ,
    parameter int BLINK_DIV  = 12500000
`endif
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_wr_valid,
    output logic                             o_wr_ready,
    input  logic [5:0]                       i_wr_char,
    input  logic                             i_wr_last,
    input  logic                             i_clear,
    input  logic                             i_run,
`ifdef SEGMENT_TXT_SCROLL_BLINK_EN
    input  logic                             i_blink,
`endif
    output logic [5:0]                       o_val,
    output logic [DIGITS-1:0]                o_dig,
    output logic [$clog2(MSG_DEPTH+1)-1:0]   o_len
);

    localparam int LEN_W    = $clog2(MSG_DEPTH + 1);
    localparam int ADDR_W   = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W   = $clog2(SCAN_DIV);
    localparam int SCROLL_W = $clog2(SCROLL_DIV);
    localparam int IDX_W    = LEN_W + DIG_W;
    localparam logic [5:0] BLANK = 6'h3F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      offset_q, offset_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [SCROLL_W-1:0]   scroll_cnt_q, scroll_cnt_d;
    logic [DIG_W-1:0]      dig_idx_q, dig_idx_d;
    logic                  upd_q, upd_d;
    logic [5:0]            val_q, val_d;
    logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;

    logic [5:0]            mem_q [MSG_DEPTH];
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [5:0]            mem_wdata;

    logic                  scrolls;
    logic                  wr_ready;
    logic                  accept;
    logic [LEN_W-1:0]      wr_base;
    logic [LEN_W-1:0]      wr_count;
    logic                  commit;
    logic [IDX_W-1:0]      win_idx;
    logic                  show_char;
    logic [5:0]            val_sel;

`ifdef SEGMENT_TXT_SCROLL_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  blink_off_q, blink_off_d;
`endif

    always_comb begin
        scrolls  = int'(len_q) > DIGITS;
        // Refuse new text only while a long message is mid-scroll, so the window never tears.
        wr_ready = !i_clear &&
                   (state_q != SHOW || !i_run || offset_q == '0 || !scrolls);
        accept   = i_wr_valid && wr_ready;
        wr_base  = (state_q == LOAD) ? wr_ptr_q : '0;
        wr_count = wr_base + LEN_W'(1);
        commit   = i_wr_last || (wr_count == LEN_W'(MSG_DEPTH));
    end

    always_comb begin
        win_idx = IDX_W'(offset_q) + IDX_W'(dig_idx_q);
        if (win_idx >= IDX_W'(len_q) + IDX_W'(1)) begin
            win_idx = win_idx - (IDX_W'(len_q) + IDX_W'(1));
        end
        // Short messages sit left-aligned; long ones show the trailing blank at index len.
        if (scrolls) begin
            show_char = win_idx != IDX_W'(len_q);
        end else begin
            show_char = IDX_W'(dig_idx_q) < IDX_W'(len_q);
        end
        val_sel = BLANK;
        if (state_q == SHOW && show_char) begin
            val_sel = mem_q[win_idx[ADDR_W-1:0]];
        end
`ifdef SEGMENT_TXT_SCROLL_BLINK_EN
        if (state_q == SHOW && i_blink && blink_off_q) begin
            val_sel = BLANK;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        len_d        = len_q;
        offset_d     = offset_q;
        scroll_cnt_d = scroll_cnt_q;
        scan_cnt_d   = scan_cnt_q;
        dig_idx_d    = dig_idx_q;
        upd_d        = 1'b0;
        val_d        = val_q;
        dig_sel_d    = dig_sel_q;
        mem_we       = 1'b0;
        mem_addr     = wr_base[ADDR_W-1:0];
        mem_wdata    = i_wr_char;

        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            dig_idx_d  = (dig_idx_q == DIG_W'(DIGITS - 1)) ? '0 : dig_idx_q + DIG_W'(1);
            upd_d      = 1'b1;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end

        // Output registers refresh one clock after the digit index moves.
        if (upd_q) begin
            val_d     = val_sel;
            dig_sel_d = ~(DIGITS'(1) << dig_idx_q);
        end

        if (i_clear) begin
            state_d      = IDLE;
            wr_ptr_d     = '0;
            len_d        = '0;
            offset_d     = '0;
            scroll_cnt_d = '0;
        end else if (accept) begin
            mem_we = 1'b1;
            if (commit) begin
                state_d      = SHOW;
                wr_ptr_d     = '0;
                len_d        = wr_count;
                offset_d     = '0;
                scroll_cnt_d = '0;
            end else begin
                state_d  = LOAD;
                wr_ptr_d = wr_count;
                if (state_q != LOAD) begin
                    len_d    = '0;
                    offset_d = '0;
                end
            end
        end else if (state_q == SHOW && scrolls && i_run) begin
            if (scroll_cnt_q == SCROLL_W'(SCROLL_DIV - 1)) begin
                scroll_cnt_d = '0;
                offset_d     = (offset_q + LEN_W'(1) == len_q) ? '0 : offset_q + LEN_W'(1);
            end else begin
                scroll_cnt_d = scroll_cnt_q + SCROLL_W'(1);
            end
        end
    end

`ifdef SEGMENT_TXT_SCROLL_BLINK_EN
    // Phase counter held at zero while blink is off so blinking always starts visible.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (!i_blink) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_off_d = !blink_off_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            len_q        <= '0;
            offset_q     <= '0;
            scan_cnt_q   <= '0;
            scroll_cnt_q <= '0;
            dig_idx_q    <= '0;
            upd_q        <= 1'b0;
            val_q        <= BLANK;
            dig_sel_q    <= '1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            len_q        <= len_d;
            offset_q     <= offset_d;
            scan_cnt_q   <= scan_cnt_d;
            scroll_cnt_q <= scroll_cnt_d;
            dig_idx_q    <= dig_idx_d;
            upd_q        <= upd_d;
            val_q        <= val_d;
            dig_sel_q    <= dig_sel_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign o_wr_ready = wr_ready;
    assign o_val      = val_q;
    assign o_dig      = dig_sel_q;
    assign o_len      = len_q;

endmodule

// File: tb/tb_segment_txt_scroll.sv
// Directed bench for segment_txt_scroll with a 4-digit, 8-character build.
module tb_segment_txt_scroll;

    localparam int DIGITS     = 4;
    localparam int MSG_DEPTH  = 8;
    localparam int SCAN_DIV   = 2;
    localparam int SCROLL_DIV = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [5:0] wr_char = 6'h00;
    logic       wr_last = 1'b0;
    logic       clear = 1'b0;
    logic       run = 1'b0;
    logic [5:0] val;
    logic [3:0] dig;
    logic [3:0] len;
`ifdef SEGMENT_TXT_SCROLL_BLINK_EN
    logic       blink = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    segment_txt_scroll #(
        .DIGITS(DIGITS), .MSG_DEPTH(MSG_DEPTH), .SCAN_DIV(SCAN_DIV), .SCROLL_DIV(SCROLL_DIV)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_char(wr_char), .i_wr_last(wr_last), .i_clear(clear), .i_run(run),
`ifdef SEGMENT_TXT_SCROLL_BLINK_EN
        .i_blink(blink),
`endif
        .o_val(val), .o_dig(dig), .o_len(len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_char(input logic [5:0] c, input logic last);
        int n;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_char  = c;
        wr_last  = last;
        n = 0;
        while (!wr_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) chk("write_ready_timeout", {31'd0, wr_ready}, 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic flush();
        repeat (20) @(negedge clk);
    endtask

    task automatic check_slot(input string tag, input logic [3:0] pat, input logic [5:0] exp);
        int n;
        n = 0;
        while (dig !== pat && n < 32) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_dig"}, {28'd0, dig}, {28'd0, pat});
        if (dig === pat) chk({tag, "_val"}, {26'd0, val}, {26'd0, exp});
    endtask

    task automatic check_window(input string tag, input logic [5:0] v0, input logic [5:0] v1,
                                input logic [5:0] v2, input logic [5:0] v3);
        check_slot({tag, "_d0"}, 4'b1110, v0);
        check_slot({tag, "_d1"}, 4'b1101, v1);
        check_slot({tag, "_d2"}, 4'b1011, v2);
        check_slot({tag, "_d3"}, 4'b0111, v3);
    endtask

    task automatic run_for(input int clocks);
        @(negedge clk);
        run = 1'b1;
        repeat (clocks) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_dig", {28'd0, dig}, 32'hF);
        chk("rst_val", {26'd0, val}, 32'h3F);
        chk("rst_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_len", {28'd0, len}, 32'd0);

        // Short static message, left-aligned.
        write_char(6'h11, 1'b0);
        write_char(6'h12, 1'b1);
        @(negedge clk);
        chk("short_len", {28'd0, len}, 32'd2);
        flush();
        check_window("short", 6'h11, 6'h12, 6'h3F, 6'h3F);
        run = 1'b1;
        repeat (40) @(negedge clk);
        chk("short_run_ready", {31'd0, wr_ready}, 32'd1);
        check_window("short_run", 6'h11, 6'h12, 6'h3F, 6'h3F);
        run = 1'b0;

        // Six-character message scrolls through a 4-digit window.
        for (int i = 0; i < 6; i++) write_char(6'(i), i == 5);
        @(negedge clk);
        chk("long_len", {28'd0, len}, 32'd6);
        flush();
        check_window("off0", 6'h00, 6'h01, 6'h02, 6'h03);
        run_for(16);
        chk("off1_ready", {31'd0, wr_ready}, 32'd0);
        run = 1'b0;
        flush();
        check_window("off1", 6'h01, 6'h02, 6'h03, 6'h04);
        run_for(64);
        chk("off5_ready", {31'd0, wr_ready}, 32'd0);
        run = 1'b0;
        flush();
        check_window("off5", 6'h05, 6'h3F, 6'h00, 6'h01);
        run_for(16);
        chk("wrap_ready", {31'd0, wr_ready}, 32'd1);
        run = 1'b0;
        flush();
        check_window("wrap", 6'h00, 6'h01, 6'h02, 6'h03);

        // Eight characters without last auto-commit; a ninth restarts loading.
        for (int i = 0; i < 8; i++) write_char(6'h20 + 6'(i), 1'b0);
        @(negedge clk);
        chk("auto_len", {28'd0, len}, 32'd8);
        flush();
        check_window("auto", 6'h20, 6'h21, 6'h22, 6'h23);
        write_char(6'h0A, 1'b0);
        flush();
        check_slot("reload_blank", 4'b1110, 6'h3F);
        write_char(6'h0B, 1'b1);
        @(negedge clk);
        chk("reload_len", {28'd0, len}, 32'd2);
        flush();
        check_window("reload", 6'h0A, 6'h0B, 6'h3F, 6'h3F);

        // Clear beats a simultaneous write.
        @(negedge clk);
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_char  = 6'h15;
        wr_last  = 1'b1;
        #1;
        chk("clear_ready", {31'd0, wr_ready}, 32'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        @(negedge clk);
        chk("clear_len", {28'd0, len}, 32'd0);
        flush();
        check_window("clear", 6'h3F, 6'h3F, 6'h3F, 6'h3F);
        write_char(6'h07, 1'b1);
        @(negedge clk);
        chk("post_clear_len", {28'd0, len}, 32'd1);
        flush();
        check_slot("post_clear", 4'b1110, 6'h07);
        check_slot("post_clear", 4'b1101, 6'h3F);

        // Asynchronous reset in the middle of a load.
        write_char(6'h01, 1'b0);
        write_char(6'h02, 1'b0);
        flush();
        check_slot("pre_rst", 4'b1101, 6'h3F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dig", {28'd0, dig}, 32'hF);
        chk("async_rst_val", {26'd0, val}, 32'h3F);
        chk("async_rst_ready", {31'd0, wr_ready}, 32'd1);
        chk("async_rst_len", {28'd0, len}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        write_char(6'h09, 1'b1);
        @(negedge clk);
        chk("after_rst_len", {28'd0, len}, 32'd1);
        flush();
        check_slot("after_rst", 4'b1110, 6'h09);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
